xpmwrap_distram_fifo: RTL and testbench

XPMWRAP_DISTRAM_FIFO -- requirements
Module: xpmwrap_distram_fifo

---
 rtl/xpmwrap_pkg.sv | 31 +++
 rtl/xpmwrap_distram_sdp.sv | 29 ++
 rtl/xpmwrap_distram_fifo.sv | 149 ++++++++++++++
 tb/tb_xpmwrap_distram_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xpmwrap_pkg.sv
// Shared helpers for the xpmwrap FIFO family: occupancy-width helper and
// parameter legality checks evaluated at elaboration.
package xpmwrap_pkg;

    localparam int MIN_ADDR_WIDTH = 2;
    localparam int MAX_ADDR_WIDTH = 10;
    localparam int MIN_DATA_WIDTH = 1;
    localparam int MAX_DATA_WIDTH = 1024;

    // Occupancy must represent 0..DEPTH inclusive, so one bit wider than a pointer.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit addr_width_ok(input int addr_width);
        return (addr_width >= MIN_ADDR_WIDTH) && (addr_width <= MAX_ADDR_WIDTH);
    endfunction

    function automatic bit data_width_ok(input int data_width);
        return (data_width >= MIN_DATA_WIDTH) && (data_width <= MAX_DATA_WIDTH);
    endfunction

    function automatic bit prog_full_ok(input int thresh, input int addr_width);
        return (thresh >= 1) && (thresh <= (1 << addr_width));
    endfunction

    function automatic bit prog_empty_ok(input int thresh, input int addr_width);
        return (thresh >= 0) && (thresh <= (1 << addr_width) - 1);
    endfunction

endpackage

// File: rtl/xpmwrap_distram_sdp.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset,
// so synthesis maps it onto distributed (LUT) RAM.
module xpmwrap_distram_sdp
    import xpmwrap_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/xpmwrap_distram_fifo.sv
// First-word fall-through FIFO on distributed RAM with a registered head
// entry; capacity DEPTH includes the head register.
module xpmwrap_distram_fifo
    import xpmwrap_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 6,
    parameter int PROG_FULL_THRESH  = 48,
    parameter int PROG_EMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  prog_full,
    output logic                  prog_empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = cnt_width(ADDR_WIDTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESH);

    if (!addr_width_ok(ADDR_WIDTH)) begin : g_bad_addr_width
        $error("xpmwrap_distram_fifo: ADDR_WIDTH out of range 2..10");
    end
    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
        $error("xpmwrap_distram_fifo: DATA_WIDTH out of range 1..1024");
    end
    if (!prog_full_ok(PROG_FULL_THRESH, ADDR_WIDTH)) begin : g_bad_prog_full
        $error("xpmwrap_distram_fifo: PROG_FULL_THRESH out of range 1..DEPTH");
    end
    if (!prog_empty_ok(PROG_EMPTY_THRESH, ADDR_WIDTH)) begin : g_bad_prog_empty
        $error("xpmwrap_distram_fifo: PROG_EMPTY_THRESH out of range 0..DEPTH-1");
    end

    logic                  s_ready_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_nxt;
    logic                  prog_full_q;
    logic                  prog_empty_q;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] head_data_p1;
    logic                  vld_p1;

    logic push;
    logic pop;
    logic ram_empty;
    logic load_head;
    logic bypass;
    logic ram_we;

    assign push      = s_valid & s_ready_q;
    assign pop       = vld_p1 & m_ready;
    // Everything not in the head register lives in RAM.
    assign ram_empty = (count_q == CW'(vld_p1));
    assign load_head = ~vld_p1 | pop;
    assign bypass    = load_head & ram_empty & push;
    assign ram_we    = push & ~bypass;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    xpmwrap_distram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (s_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Stage p0 -> occupancy, pointers and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            s_ready_q    <= 1'b0;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
        end else if (flush) begin
            count_q      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            s_ready_q    <= 1'b1;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
        end else begin
            count_q      <= count_nxt;
            s_ready_q    <= (count_nxt < DEPTH_C);
            prog_full_q  <= (count_nxt >= PF_C);
            prog_empty_q <= (count_nxt <= PE_C);
            if (ram_we) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (load_head && !ram_empty) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Stage p1 -> head-of-queue register feeding m_data/m_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data_p1 <= '0;
            vld_p1       <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load_head) begin
            if (!ram_empty) begin
                head_data_p1 <= ram_rdata;
                vld_p1       <= 1'b1;
            end else if (push) begin
                head_data_p1 <= s_data;
                vld_p1       <= 1'b1;
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign s_ready    = s_ready_q;
    assign count      = count_q;
    assign prog_full  = prog_full_q;
    assign prog_empty = prog_empty_q;
    assign m_data     = head_data_p1;
    assign m_valid    = vld_p1;

endmodule

// File: tb/tb_xpmwrap_distram_fifo.sv
// Bench for xpmwrap_distram_fifo (default parameters): directed vector table,
// corner sequences and randomized traffic against a queue-based model.
module tb_xpmwrap_distram_fifo;

    localparam int DEPTH = 64;
    localparam int PFT   = 48;
    localparam int PET   = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [6:0]  count;
    logic        prog_full;
    logic        prog_empty;

    xpmwrap_distram_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .count      (count),
        .prog_full  (prog_full),
        .prog_empty (prog_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Reference model: a plain queue of accepted words plus the ready state.
    logic [31:0] q[$];
    bit          rdy_m;

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        logic        fl;
        logic        mv;
        logic [31:0] md;
        int          cnt;
        logic        sr;
        logic        pf;
        logic        pe;
    } vec_t;

    vec_t vecs[15];

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_edge(input logic sv, input logic [31:0] sd, input logic mr, input logic fl);
        bit pu;
        bit po;
        if (fl) begin
            q.delete();
        end else begin
            pu = sv && rdy_m;
            po = (q.size() != 0) && mr;
            if (po) void'(q.pop_front());
            if (pu) q.push_back(sd);
        end
        rdy_m = (q.size() < DEPTH);
    endtask

    task automatic step(input logic sv, input logic [31:0] sd, input logic mr, input logic fl);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        @(posedge clk);
        #1;
        model_edge(sv, sd, mr, fl);
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".m_valid"}, 32'(m_valid), 32'(q.size() != 0));
        if (q.size() != 0) cmp({tag, ".m_data"}, m_data, q[0]);
        cmp({tag, ".count"}, 32'(count), 32'(q.size()));
        cmp({tag, ".s_ready"}, 32'(s_ready), 32'(rdy_m));
        cmp({tag, ".prog_full"}, 32'(prog_full), 32'(q.size() >= PFT));
        cmp({tag, ".prog_empty"}, 32'(prog_empty), 32'(q.size() <= PET));
    endtask

    initial begin
        int          pushed;
        int          cycles;
        logic        sv;
        logic        mr;
        logic        prev_mv;
        logic [31:0] prev_md;

        rst_n   = 1'b0;
        flush   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        q.delete();
        rdy_m   = 1'b0;

        //            sv  sd            mr  fl  mv  md            cnt sr  pf  pe
        vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 32'h2,        1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 2, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 32'h3,        1'b1, 1'b0, 1'b1, 32'h2,        2, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h2,        2, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h3,        1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 32'h4,        1'b1, 1'b0, 1'b1, 32'h4,        1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 32'h5,        1'b1, 1'b0, 1'b1, 32'h5,        1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'h6,        1'b0, 1'b0, 1'b1, 32'h5,        2, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 32'h7,        1'b0, 1'b0, 1'b1, 32'h5,        3, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 32'h8,        1'b0, 1'b0, 1'b1, 32'h5,        4, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 32'h9,        1'b0, 1'b0, 1'b1, 32'h5,        5, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 32'hAA,       1'b0, 1'b1, 1'b0, 32'h0,        0, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 32'hBB,       1'b0, 1'b0, 1'b1, 32'hBB,       1, 1'b1, 1'b0, 1'b1};

        // Reset state while rst_n is held low
        repeat (3) @(posedge clk);
        #1;
        cmp("rst.count", 32'(count), 32'd0);
        cmp("rst.m_valid", 32'(m_valid), 32'd0);
        cmp("rst.m_data", m_data, 32'd0);
        cmp("rst.s_ready", 32'(s_ready), 32'd0);
        cmp("rst.prog_full", 32'(prog_full), 32'd0);
        cmp("rst.prog_empty", 32'(prog_empty), 32'd1);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].sv, vecs[i].sd, vecs[i].mr, vecs[i].fl);
            cmp($sformatf("vec%0d.m_valid", i), 32'(m_valid), 32'(vecs[i].mv));
            if (vecs[i].mv) cmp($sformatf("vec%0d.m_data", i), m_data, vecs[i].md);
            cmp($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].cnt));
            cmp($sformatf("vec%0d.s_ready", i), 32'(s_ready), 32'(vecs[i].sr));
            cmp($sformatf("vec%0d.prog_full", i), 32'(prog_full), 32'(vecs[i].pf));
            cmp($sformatf("vec%0d.prog_empty", i), 32'(prog_empty), 32'(vecs[i].pe));
        end

        // Fill to capacity with the consumer stalled
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 32'hF000_0000 + 32'(i), 1'b0, 1'b0);
            check_model($sformatf("fill%0d", i));
            if (i == PFT - 1) cmp("fill.pf_below", 32'(prog_full), 32'd0);
            if (i == PFT) cmp("fill.pf_at", 32'(prog_full), 32'd1);
        end
        cmp("full.s_ready", 32'(s_ready), 32'd0);
        cmp("full.count", 32'(count), 32'd64);
        step(1'b1, 32'hDEAD_0065, 1'b0, 1'b0);
        check_model("full.ignored");
        cmp("full.ignored_count", 32'(count), 32'd64);
        // Push and pop together while full: only the pop is taken
        step(1'b1, 32'hBEEF_0066, 1'b1, 1'b0);
        check_model("full.pushpop");
        cmp("full.pushpop_count", 32'(count), 32'd63);
        cmp("full.pushpop_s_ready", 32'(s_ready), 32'd1);
        cmp("full.pushpop_head", m_data, 32'hF000_0002);

        // Randomized traffic with consumer stalls
        step(1'b0, 32'h0, 1'b0, 1'b1);
        pushed = 0;
        cycles = 0;
        while (pushed < 1000 && cycles < 20000) begin
            sv      = ($urandom_range(0, 3) != 0);
            mr      = ($urandom_range(0, 1) != 0);
            prev_mv = m_valid;
            prev_md = m_data;
            if (sv && rdy_m) pushed++;
            step(sv, $urandom, mr, 1'b0);
            cycles++;
            check_model("rnd");
            if (prev_mv && !mr) begin
                cmp("rnd.stall_valid", 32'(m_valid), 32'd1);
                cmp("rnd.stall_data", m_data, prev_md);
            end
        end
        cmp("rnd.budget", 32'(pushed >= 1000), 32'd1);
        while (q.size() != 0 && cycles < 22000) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            cycles++;
            check_model("drain");
        end
        cmp("drain.count", 32'(count), 32'd0);

        // Flush at count=10 with a simultaneous push
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
        cmp("flush.pre_count", 32'(count), 32'd10);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        check_model("flush");
        cmp("flush.count", 32'(count), 32'd0);
        cmp("flush.m_valid", 32'(m_valid), 32'd0);
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check_model("flush.after");
        cmp("flush.after_head", m_data, 32'h1234_5678);
        cmp("flush.after_count", 32'(count), 32'd1);

        // Asynchronous reset mid-stream at count=20
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
        cmp("arst.pre_count", 32'(count), 32'd20);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        cmp("arst.count", 32'(count), 32'd0);
        cmp("arst.m_valid", 32'(m_valid), 32'd0);
        cmp("arst.m_data", m_data, 32'd0);
        cmp("arst.s_ready", 32'(s_ready), 32'd0);
        cmp("arst.prog_full", 32'(prog_full), 32'd0);
        cmp("arst.prog_empty", 32'(prog_empty), 32'd1);
        q.delete();
        rdy_m = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check_model("arst.release");
        step(1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
        check_model("arst.push");
        cmp("arst.new_head", m_data, 32'hC0DE_0001);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check_model("arst.pop");
        cmp("arst.final_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
